// File: rtl/cfg_desc_pkg.sv
// Shared types, address map and decode for the configuration descriptor responder.
// The published configuration type and its default FPGA build are defined here too.
package cfg_desc_pkg;

  typedef struct packed {
    bit RVA, RVB, RVC, RVH, RVV, RVZCB, FpuEn, RVF, RVD, CvxifEn, RVS, RVU, DebugEn, ZiCondExtEn;
    int unsigned NrPMPEntries, NrLoadBufEntries, MaxOutstandingStores, NrCommitPorts;
    int unsigned BHTEntries, BTBEntries, RASDepth;
    int unsigned NrNonIdempotentRules, NrExecuteRegionRules, NrCachedRegionRules;
    logic [1023:0] NonIdempotentAddrBase, NonIdempotentLength;
    logic [1023:0] ExecuteRegionAddrBase, ExecuteRegionLength;
    logic [1023:0] CachedRegionAddrBase, CachedRegionLength;
  } cva6_cfg_t;

  // Execute rule 3 carries data beyond the rule count on purpose: it must never be visible.
  localparam cva6_cfg_t cva6_cfg = '{
    RVA: 1'b1, RVB: 1'b0, RVC: 1'b0, RVH: 1'b0, RVV: 1'b0, RVZCB: 1'b0, FpuEn: 1'b0,
    RVF: 1'b0, RVD: 1'b0, CvxifEn: 1'b0, RVS: 1'b1, RVU: 1'b1, DebugEn: 1'b1, ZiCondExtEn: 1'b0,
    NrPMPEntries: 0, NrLoadBufEntries: 2, MaxOutstandingStores: 7, NrCommitPorts: 1,
    BHTEntries: 128, BTBEntries: 32, RASDepth: 2,
    NrNonIdempotentRules: 2, NrExecuteRegionRules: 3, NrCachedRegionRules: 1,
    NonIdempotentAddrBase: {896'h0, 64'h2_0000_0000, 64'h0},
    NonIdempotentLength:   {896'h0, 64'h1_0000_0000, 64'h8000_0000},
    ExecuteRegionAddrBase: {768'h0, 64'hDEAD_0000, 64'h8000_0000, 64'h1_0000, 64'h0},
    ExecuteRegionLength:   {832'h0, 64'h4000_0000, 64'h1_0000, 64'h1000},
    CachedRegionAddrBase:  {960'h0, 64'h8000_0000},
    CachedRegionLength:    {960'h0, 64'h4000_0000}
  };

  localparam int unsigned IdMaxWidth = 8;

  localparam logic [7:0]  OffMagic      = 8'h00;
  localparam logic [7:0]  OffFeatures   = 8'h04;
  localparam logic [7:0]  OffSizing     = 8'h08;
  localparam logic [7:0]  OffPredictor  = 8'h0C;
  localparam logic [7:0]  OffRas        = 8'h10;
  localparam logic [7:0]  OffRuleCounts = 8'h14;
  localparam logic [31:0] ExecTableBase = 32'h100;
  localparam logic [31:0] DescSpaceEnd  = 32'h400;
  localparam logic [31:0] Magic         = 32'hC5A6_0001;

  localparam int unsigned FeatRVA = 0,  FeatRVB = 1,  FeatRVC = 2,   FeatRVH = 3;
  localparam int unsigned FeatRVV = 4,  FeatRVZCB = 5, FeatFpu = 6,  FeatRVF = 7;
  localparam int unsigned FeatRVD = 8,  FeatCvxif = 9, FeatRVS = 10, FeatRVU = 11;
  localparam int unsigned FeatDebug = 12, FeatZiCond = 13;

  typedef struct packed {
    logic [31:0]           rdata;
    logic                  err;
    logic [IdMaxWidth-1:0] id;
  } resp_t;

  function automatic logic [7:0] sat8(int unsigned v);
    return (v > 255) ? 8'hFF : v[7:0];
  endfunction

  function automatic logic [15:0] sat16(int unsigned v);
    return (v > 65535) ? 16'hFFFF : v[15:0];
  endfunction

  function automatic logic [31:0] features(cva6_cfg_t cfg);
    logic [31:0] f;
    f = '0;
    f[FeatRVA]   = cfg.RVA;     f[FeatRVB]   = cfg.RVB;   f[FeatRVC]    = cfg.RVC;
    f[FeatRVH]   = cfg.RVH;     f[FeatRVV]   = cfg.RVV;   f[FeatRVZCB]  = cfg.RVZCB;
    f[FeatFpu]   = cfg.FpuEn;   f[FeatRVF]   = cfg.RVF;   f[FeatRVD]    = cfg.RVD;
    f[FeatCvxif] = cfg.CvxifEn; f[FeatRVS]   = cfg.RVS;   f[FeatRVU]    = cfg.RVU;
    f[FeatDebug] = cfg.DebugEn; f[FeatZiCond] = cfg.ZiCondExtEn;
    return f;
  endfunction

  // Id is left zero; the caller attaches the request tag.
  function automatic resp_t decode(cva6_cfg_t cfg, logic [31:0] addr, logic we);
    resp_t         r;
    logic [1023:0] base, len;
    logic [63:0]   b, l;
    int unsigned   cnt;
    r = '0; base = '0; len = '0; cnt = 0;
    if (we || addr[1:0] != 2'b00 || addr >= DescSpaceEnd) begin
      r.err = 1'b1;
    end else if (addr < ExecTableBase) begin
      case (addr[7:0])
        OffMagic:      r.rdata = Magic;
        OffFeatures:   r.rdata = features(cfg);
        OffSizing:     r.rdata = {sat8(cfg.NrPMPEntries), sat8(cfg.NrLoadBufEntries),
                                  sat8(cfg.MaxOutstandingStores), sat8(cfg.NrCommitPorts)};
        OffPredictor:  r.rdata = {sat16(cfg.BHTEntries), sat16(cfg.BTBEntries)};
        OffRas:        r.rdata = cfg.RASDepth;
        OffRuleCounts: r.rdata = {8'h0, sat8(cfg.NrCachedRegionRules),
                                  sat8(cfg.NrExecuteRegionRules), sat8(cfg.NrNonIdempotentRules)};
        default:       r.err = 1'b1;
      endcase
    end else begin
      case (addr[9:8])
        2'd1:    begin base = cfg.ExecuteRegionAddrBase; len = cfg.ExecuteRegionLength;   cnt = cfg.NrExecuteRegionRules; end
        2'd2:    begin base = cfg.CachedRegionAddrBase;  len = cfg.CachedRegionLength;    cnt = cfg.NrCachedRegionRules;  end
        default: begin base = cfg.NonIdempotentAddrBase; len = cfg.NonIdempotentLength; cnt = cfg.NrNonIdempotentRules; end
      endcase
      b = 64'(base >> {addr[7:4], 6'b0});
      l = 64'(len >> {addr[7:4], 6'b0});
      if ({28'b0, addr[7:4]} < cnt) begin
        case (addr[3:2])
          2'd0:    r.rdata = b[31:0];
          2'd1:    r.rdata = b[63:32];
          2'd2:    r.rdata = l[31:0];
          default: r.rdata = l[63:32];
        endcase
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cva6_fifo_v3.sv
// Small synchronous FIFO, registered head (no fall-through), asynchronous active-high reset.
module cva6_fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o
);
  localparam int unsigned PtrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntWidth = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;

  function automatic logic [PtrWidth-1:0] ptr_inc(logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(DEPTH - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && (cnt_q != CntWidth'(DEPTH));

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    cnt_d = cnt_q + CntWidth'(do_push) - CntWidth'(do_pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/cfg_desc_responder.sv
// Read-only descriptor space publishing the build configuration: one registered
// decode stage feeding an in-order response FIFO, with credit-based request grant.
module cfg_desc_responder
  import cfg_desc_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg   = cva6_cfg,
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned RespDepth = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic                 we_i,
  input  logic [31:0]          wdata_i,
  input  logic [IdWidth-1:0]   id_i,
  output logic                 rvalid_o,
  input  logic                 rready_i,
  output logic [31:0]          rdata_o,
  output logic                 err_o,
  output logic [IdWidth-1:0]   id_o
);
  localparam int unsigned CntWidth = 4;

  logic [CntWidth-1:0]  outstanding_q, outstanding_d;
  logic                 s1_valid_q, s1_valid_d;
  logic [AddrWidth-1:0] s1_addr_q, s1_addr_d;
  logic                 s1_we_q, s1_we_d;
  logic [IdWidth-1:0]   s1_id_q, s1_id_d;
  logic                 accept, pop, fifo_empty;
  resp_t                push_data, head;

  // Credit covers S1 plus FIFO, so a push can never find the FIFO full.
  assign gnt_o  = !rst_i && (outstanding_q < CntWidth'(RespDepth));
  assign accept = req_i && gnt_o;
  assign pop    = rvalid_o && rready_i;

  always_comb begin
    s1_valid_d    = accept;
    s1_addr_d     = accept ? addr_i : s1_addr_q;
    s1_we_d       = accept ? we_i   : s1_we_q;
    s1_id_d       = accept ? id_i   : s1_id_q;
    outstanding_d = outstanding_q;
    if (accept && !pop)      outstanding_d = outstanding_q + CntWidth'(1);
    else if (!accept && pop) outstanding_d = outstanding_q - CntWidth'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
      s1_valid_q    <= 1'b0;
      s1_addr_q     <= '0;
      s1_we_q       <= 1'b0;
      s1_id_q       <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      s1_valid_q    <= s1_valid_d;
      s1_addr_q     <= s1_addr_d;
      s1_we_q       <= s1_we_d;
      s1_id_q       <= s1_id_d;
    end
  end

  always_comb begin
    push_data    = decode(CVA6Cfg, 32'(s1_addr_q), s1_we_q);
    push_data.id = IdMaxWidth'(s1_id_q);
  end

  cva6_fifo_v3 #(
    .DATA_WIDTH ($bits(resp_t)),
    .DEPTH      (RespDepth)
  ) i_resp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (s1_valid_q),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head),
    .empty_o (fifo_empty)
  );

  // Idle outputs read zero rather than exposing a stale FIFO slot.
  assign rvalid_o = !fifo_empty;
  assign rdata_o  = rvalid_o ? head.rdata : '0;
  assign err_o    = rvalid_o & head.err;
  assign id_o     = rvalid_o ? head.id[IdWidth-1:0] : '0;

  logic unused_bits;
  assign unused_bits = ^{wdata_i, head.id};
endmodule

// File: doc/cfg_desc_responder.md
Name: cfg_desc_responder

Overview:
- Read-only responder exposing the elaborated `config_pkg::cva6_cfg_t` (feature bits, sizing, PMA region tables) as a 32-bit word-addressed descriptor space.
- Software, the debug module, and the verification bench discover the build configuration at run time instead of hard-coding it.
- Sits on a request/grant, response-valid/ready port behind the peripheral crossbar.
- One registered decode stage feeds a response FIFO, giving backpressure-safe, in-order responses with ID echo.

Parameters:
- CVA6Cfg, default `cva6_config_pkg::cva6_cfg`: configuration being published.
- AddrWidth, default 10: byte address width; descriptor space is 1 KiB.
- IdWidth, default 4: transaction tag width.
- RespDepth, default 3: response FIFO depth and outstanding-transaction credit; legal range 1..8.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_i  in  1  request valid
- gnt_o  out  1  request accepted this cycle when req_i && gnt_o
- addr_i  in  AddrWidth  byte address
- we_i  in  1  write request (never performed)
- wdata_i  in  32  ignored
- id_i  in  IdWidth  request tag
- rvalid_o  out  1  response valid
- rready_i  in  1  response consumed when rvalid_o && rready_i
- rdata_o  out  32  read data
- err_o  out  1  error response
- id_o  out  IdWidth  echoed tag

Behaviour:
- Reset values: gnt_o=0 while rst_i is high; rvalid_o=0, rdata_o=0, err_o=0, id_o=0.
- Reset mid-operation: the S1 stage, FIFO and credit counter clear immediately; in-flight responses are dropped.
- Credit:
  - outstanding_q = S1 occupancy + FIFO count.
  - gnt_o = !rst_i && (outstanding_q < RespDepth); no combinational path from rready_i.
  - Update: outstanding_q += accept - pop, where a simultaneous accept and pop leaves it unchanged.
- Pipeline timing:
  - Accept in cycle N → S1 holds {addr, we, id} in N+1.
  - The decoded response is pushed to the FIFO at the end of N+1.
  - rvalid_o is asserted from N+2 (2-cycle latency).
  - FIFO head drives rvalid_o/rdata_o/err_o/id_o directly.
- Throughput: responses are strictly in order. With rready_i=1, RespDepth≥3 sustains one transaction per cycle; RespDepth=1 gives one per 3 cycles.
- Backpressure: with rready_i=0, responses hold stable. gnt_o drops once outstanding_q reaches RespDepth and rises the cycle after a pop.
- Decode, applied in the S1 stage:
  - 0x000: magic 0xC5A6_0001.
  - 0x004 feature bits: [0] RVA, [1] RVB, [2] RVC, [3] RVH, [4] RVV, [5] RVZCB, [6] FpuEn, [7] RVF, [8] RVD, [9] CvxifEn, [10] RVS, [11] RVU, [12] DebugEn, [13] ZiCondExtEn; the rest read 0.
  - 0x008: {NrPMPEntries, NrLoadBufEntries, MaxOutstandingStores, NrCommitPorts}, 8 bits each, MSB first. Each field saturates at 255.
  - 0x00C: {BHTEntries[15:0], BTBEntries[15:0]}, each field saturating at 0xFFFF.
  - 0x010: RASDepth.
  - 0x014: {8'h0, NrCachedRegionRules, NrExecuteRegionRules, NrNonIdempotentRules}.
  - 0x100–0x1FF: execute table; 0x200–0x2FF: cached table; 0x300–0x3FF: non-idempotent table.
- Region table layout:
  - Rule i = addr[7:4]; word addr[3:2] selects base_lo, base_hi, len_lo, len_hi.
  - Rule i occupies bits [64i +: 64] of the 1024-bit vectors.
  - i ≥ that table's rule count → rdata 0, err 0.
- Errors (each returns rdata 0, err 1):
  - addr[1:0]≠0;
  - addresses 0x018–0x0FF;
  - any we_i=1 request. Writes have no side effects but still consume a credit and return in order.

Decomposition:
- Shared package `cfg_desc_pkg`: address offsets, table bases, magic, feature bit indices, and `resp_t` {rdata, err, id}.
- Single sub-module: `cva6_fifo_v3` instance (DATA_WIDTH = $bits(resp_t), DEPTH = RespDepth) as the response FIFO.
- Decode is a function in the package.

Test Plan:
- FPGA config, read 0x000, 0x004, 0x008 → responses 0xC5A6_0001, 0x0000_1C01, 0x0002_0701, each arriving 2 cycles after grant.
- Read 0x00C, 0x014 → 0x0080_0020 and 0x0001_0302.
- Read 0x120, 0x128, 0x200, 0x110 → 0x8000_0000, 0x4000_0000, 0x8000_0000, 0x0001_0000. Read 0x130 (rule 3) → 0 with err=0.
- Write to 0x004, read 0x002, read 0x050 → all err=1, rdata=0; a following read of 0x004 still returns 0x1C01.
- Back-to-back 10 reads with ids 0..9 and rready_i=0 → gnt_o stops after 3 accepts. Release rready_i → all ids return in order; gnt_o sustains 1/cycle thereafter.
- Assert rst_i with 3 outstanding → rvalid_o=0 and gnt_o=0 immediately. After release, gnt_o=1 and no stale responses are returned.
